// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// opcode constants, datapath select codes and the decoded control word.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  localparam logic [5:0] OpcR    = 6'h00;
  localparam logic [5:0] OpcLw   = 6'h23;
  localparam logic [5:0] OpcSw   = 6'h2B;
  localparam logic [5:0] OpcBeq  = 6'h04;
  localparam logic [5:0] OpcJ    = 6'h02;
  localparam logic [5:0] OpcAddi = 6'h08;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBRegB  = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OpcR) || (op == OpcLw) || (op == OpcSw) ||
           (op == OpcBeq) || (op == OpcJ) || (op == OpcAddi);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational state -> control word decoder. Reset forces the whole word to
// zero so no request or write can leak out while the core is held in reset.
module multicycle_ctrl_outdec
  import multicycle_ctrl_pkg::*;
(
  input  logic       rst,
  input  state_e     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    if (!rst) begin
      case (state)
        StFetch: begin
          cw.mem_rd    = 1'b1;
          cw.iord      = 1'b0;
          cw.alu_src_a = 1'b0;
          cw.alu_src_b = SrcBFour;
          cw.alu_op    = AluOpAdd;
          cw.pc_source = PcSrcAlu;
          // IR and PC only latch once the fetch read actually completes
          cw.ir_write  = mem_ready;
          cw.pc_write  = mem_ready;
        end
        StDecode: begin
          cw.alu_src_a = 1'b0;
          cw.alu_src_b = SrcBImmSh;
          cw.alu_op    = AluOpAdd;
          cw.illegal   = !op_supported(op);
        end
        StMemAdr: begin
          cw.alu_src_a = 1'b1;
          cw.alu_src_b = SrcBImm;
          cw.alu_op    = AluOpAdd;
        end
        StMemRd: begin
          cw.mem_rd = 1'b1;
          cw.iord   = 1'b1;
        end
        StMemWb: begin
          cw.reg_write  = 1'b1;
          cw.reg_dst    = 1'b0;
          cw.mem_to_reg = 1'b1;
          cw.retire     = 1'b1;
        end
        StMemWr: begin
          cw.mem_wr = 1'b1;
          cw.iord   = 1'b1;
          cw.retire = mem_ready;
        end
        StExec: begin
          cw.alu_src_a = 1'b1;
          cw.alu_src_b = SrcBRegB;
          cw.alu_op    = AluOpFunct;
        end
        StAluWb: begin
          cw.reg_write  = 1'b1;
          cw.reg_dst    = 1'b1;
          cw.mem_to_reg = 1'b0;
          cw.retire     = 1'b1;
        end
        StBranch: begin
          cw.alu_src_a     = 1'b1;
          cw.alu_src_b     = SrcBRegB;
          cw.alu_op        = AluOpSub;
          cw.pc_write_cond = 1'b1;
          cw.pc_source     = PcSrcAluOut;
          cw.retire        = 1'b1;
        end
        StJump: begin
          cw.pc_write  = 1'b1;
          cw.pc_source = PcSrcJump;
          cw.retire    = 1'b1;
        end
        StAddiEx: begin
          cw.alu_src_a = 1'b1;
          cw.alu_src_b = SrcBImm;
          cw.alu_op    = AluOpAdd;
        end
        StAddiWb: begin
          cw.reg_write  = 1'b1;
          cw.reg_dst    = 1'b0;
          cw.mem_to_reg = 1'b0;
          cw.retire     = 1'b1;
        end
        default: cw = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS core: state register, next-state
// logic, PC enable and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  state_e     state_q, state_d;
  ctrl_word_t cw;
  logic [5:0] op;
  logic [CNT_W-1:0] cnt_q;

  assign op = 6'(opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cw.retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpcLw, OpcSw: state_d = StMemAdr;
          OpcR:         state_d = StExec;
          OpcBeq:       state_d = StBranch;
          OpcJ:         state_d = StJump;
          OpcAddi:      state_d = StAddiEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (op == OpcLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  multicycle_ctrl_outdec u_outdec (
    .rst       (rst),
    .state     (state_q),
    .op        (op),
    .mem_ready (mem_ready),
    .cw        (cw)
  );

  // pc_write_cond is only ever set in BRANCH, so zero matters there alone
  assign pc_en       = cw.pc_write | (cw.pc_write_cond & zero);
  assign pc_source   = cw.pc_source;
  assign iord        = cw.iord;
  assign mem_rd      = cw.mem_rd;
  assign mem_wr      = cw.mem_wr;
  assign ir_write    = cw.ir_write;
  assign alu_src_a   = cw.alu_src_a;
  assign alu_src_b   = cw.alu_src_b;
  assign alu_op      = cw.alu_op;
  assign reg_write   = cw.reg_write;
  assign reg_dst     = cw.reg_dst;
  assign mem_to_reg  = cw.mem_to_reg;
  assign retire      = cw.retire;
  assign illegal     = cw.illegal;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second instance with a 2-bit counter
// exercises the retired-count wrap.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        pc_en, iord, mem_rd, mem_wr, ir_write, alu_src_a;
  logic        reg_write, reg_dst, mem_to_reg, retire, illegal;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] retired_cnt;

  logic        s_pc_en, s_iord, s_mem_rd, s_mem_wr, s_ir_write, s_alu_src_a;
  logic        s_reg_write, s_reg_dst, s_mem_to_reg, s_retire, s_illegal;
  logic [1:0]  s_pc_source, s_alu_src_b, s_alu_op;
  logic [1:0]  s_retired_cnt;

  logic [16:0] obs_cw;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc_en, pc_source, iord, mem_rd, mem_wr, ir_write, src_a, src_b, alu_op,
  //  reg_write, reg_dst, mem_to_reg, retire, illegal}
  localparam logic [16:0] CwZero  = 17'b0_00_0_0_0_0_0_00_00_0_0_0_0_0;
  localparam logic [16:0] CwFetch = 17'b1_00_0_1_0_1_0_01_00_0_0_0_0_0;
  localparam logic [16:0] CwDec   = 17'b0_00_0_0_0_0_0_11_00_0_0_0_0_0;
  localparam logic [16:0] CwIll   = 17'b0_00_0_0_0_0_0_11_00_0_0_0_0_1;
  localparam logic [16:0] CwMAdr  = 17'b0_00_0_0_0_0_1_10_00_0_0_0_0_0;
  localparam logic [16:0] CwMRd   = 17'b0_00_1_1_0_0_0_00_00_0_0_0_0_0;
  localparam logic [16:0] CwMWb   = 17'b0_00_0_0_0_0_0_00_00_1_0_1_1_0;
  localparam logic [16:0] CwMWrS  = 17'b0_00_1_0_1_0_0_00_00_0_0_0_0_0;
  localparam logic [16:0] CwMWr   = 17'b0_00_1_0_1_0_0_00_00_0_0_0_1_0;
  localparam logic [16:0] CwExec  = 17'b0_00_0_0_0_0_1_00_10_0_0_0_0_0;
  localparam logic [16:0] CwAluWb = 17'b0_00_0_0_0_0_0_00_00_1_1_0_1_0;
  localparam logic [16:0] CwBrT   = 17'b1_01_0_0_0_0_1_00_01_0_0_0_1_0;
  localparam logic [16:0] CwBrN   = 17'b0_01_0_0_0_0_1_00_01_0_0_0_1_0;
  localparam logic [16:0] CwJump  = 17'b1_10_0_0_0_0_0_00_00_0_0_0_1_0;
  localparam logic [16:0] CwAEx   = 17'b0_00_0_0_0_0_1_10_00_0_0_0_0_0;
  localparam logic [16:0] CwAWb   = 17'b0_00_0_0_0_0_0_00_00_1_0_0_1_0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(6), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .pc_source   (pc_source),
    .iord        (iord),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .ir_write    (ir_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .retire      (retire),
    .illegal     (illegal),
    .retired_cnt (retired_cnt)
  );

  multicycle_ctrl #(.OP_W(6), .CNT_W(2)) dut_small (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (s_pc_en),
    .pc_source   (s_pc_source),
    .iord        (s_iord),
    .mem_rd      (s_mem_rd),
    .mem_wr      (s_mem_wr),
    .ir_write    (s_ir_write),
    .alu_src_a   (s_alu_src_a),
    .alu_src_b   (s_alu_src_b),
    .alu_op      (s_alu_op),
    .reg_write   (s_reg_write),
    .reg_dst     (s_reg_dst),
    .mem_to_reg  (s_mem_to_reg),
    .retire      (s_retire),
    .illegal     (s_illegal),
    .retired_cnt (s_retired_cnt)
  );

  assign obs_cw = {pc_en, pc_source, iord, mem_rd, mem_wr, ir_write, alu_src_a, alu_src_b,
                   alu_op, reg_write, reg_dst, mem_to_reg, retire, illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set at the negedge; check #1 later, then advance one cycle.
  task automatic cyc(input string tag, input logic [16:0] exp_cw);
    #1;
    chk(tag, {15'd0, obs_cw}, {15'd0, exp_cw});
    @(negedge clk);
  endtask

  task automatic cnt_chk(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, retired_cnt, exp);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    // Reset: everything gated, even with mem_ready high
    cyc("rst0", CwZero);
    mem_ready = 1'b1;
    cyc("rst1", CwZero);
    cnt_chk("rst_cnt", 32'd0);
    cyc("rst2", CwZero);

    // R-type, mem_ready low outside memory states must not matter
    rst = 1'b0; opcode = 6'h00; mem_ready = 1'b1;
    cyc("r_fetch", CwFetch);
    mem_ready = 1'b0;
    cyc("r_dec", CwDec);
    cyc("r_exec", CwExec);
    mem_ready = 1'b1;
    cyc("r_aluwb", CwAluWb);
    cnt_chk("r_cnt", 32'd1);

    // lw with two stall cycles in MEMRD
    opcode = 6'h23;
    cyc("lw_fetch", CwFetch);
    cyc("lw_dec", CwDec);
    cyc("lw_madr", CwMAdr);
    mem_ready = 1'b0;
    cyc("lw_mrd0", CwMRd);
    cyc("lw_mrd1", CwMRd);
    mem_ready = 1'b1;
    cyc("lw_mrd2", CwMRd);
    cyc("lw_mwb", CwMWb);
    cnt_chk("lw_cnt", 32'd2);

    // beq taken
    opcode = 6'h04;
    cyc("beq_t_fetch", CwFetch);
    cyc("beq_t_dec", CwDec);
    zero = 1'b1;
    cyc("beq_t_br", CwBrT);
    cnt_chk("beq_t_cnt", 32'd3);
    chk("small_cnt3", {30'd0, s_retired_cnt}, 32'd3);

    // beq not taken; zero high in DECODE must not enable the PC
    cyc("beq_n_fetch", CwFetch);
    cyc("beq_n_dec", CwDec);
    zero = 1'b0;
    cyc("beq_n_br", CwBrN);
    cnt_chk("beq_n_cnt", 32'd4);
    chk("small_wrap", {30'd0, s_retired_cnt}, 32'd0);

    // j
    opcode = 6'h02;
    cyc("j_fetch", CwFetch);
    cyc("j_dec", CwDec);
    cyc("j_jump", CwJump);
    cnt_chk("j_cnt", 32'd5);

    // addi
    opcode = 6'h08;
    cyc("addi_fetch", CwFetch);
    cyc("addi_dec", CwDec);
    cyc("addi_ex", CwAEx);
    cyc("addi_wb", CwAWb);
    cnt_chk("addi_cnt", 32'd6);

    // Illegal opcode: flagged in DECODE, straight back to FETCH, no retire
    opcode = 6'h3F;
    cyc("ill_fetch", CwFetch);
    cyc("ill_dec", CwIll);
    cnt_chk("ill_cnt", 32'd6);
    opcode = 6'h00;
    cyc("ill_back_fetch", CwFetch);
    cyc("ill_back_dec", CwDec);
    cyc("ill_back_exec", CwExec);
    cyc("ill_back_wb", CwAluWb);
    cnt_chk("ill_back_cnt", 32'd7);

    // sw interrupted by reset during MEMWR
    opcode = 6'h2B;
    cyc("sw_fetch", CwFetch);
    cyc("sw_dec", CwDec);
    cyc("sw_madr", CwMAdr);
    mem_ready = 1'b0;
    cyc("sw_mwr_stall", CwMWrS);
    rst = 1'b1; mem_ready = 1'b1;
    cyc("sw_mwr_rst", CwZero);
    rst = 1'b0;
    cyc("sw_after_rst_fetch", CwFetch);
    cnt_chk("sw_rst_cnt", 32'd0);

    // sw completing without stalls
    cyc("sw2_dec", CwDec);
    cyc("sw2_madr", CwMAdr);
    cyc("sw2_mwr", CwMWr);
    cyc("sw2_fetch", CwFetch);
    cnt_chk("sw2_cnt", 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
